cache_mem_arbiter: RTL and testbench

- Shares the single main-memory port between ICache line fills and DCache line fills/write-backs.
- Arbitrates round-robin between the two requesters.
- Sequences each granted transaction as LINE_WORDS back-to-back word accesses to a pipelined memory with fixed read latency.
- Sits between both cache controllers and the memory inside proc.

---
 rtl/cache_mem_arbiter.sv | 131 +++++++++++++
 tb/tb_cache_mem_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter that shares one pipelined memory port between ICache fills
// and DCache fills/write-backs, issuing each line as LINE_WORDS back-to-back accesses.
module cache_mem_arbiter #(
  parameter int MEM_LAT    = 2,
  parameter int LINE_WORDS = 4,
  localparam int IW        = $clog2(LINE_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ic_req,
  input  logic [15:0]   ic_addr,
  output logic          ic_grant,
  output logic          ic_rvalid,
  output logic [15:0]   ic_rdata,
  output logic [IW-1:0] ic_widx,
  output logic          ic_done,
  input  logic          dc_req,
  input  logic          dc_wr,
  input  logic [15:0]   dc_addr,
  input  logic [15:0]   dc_wdata,
  output logic          dc_grant,
  output logic          dc_rvalid,
  output logic [15:0]   dc_rdata,
  output logic [IW-1:0] dc_widx,
  output logic          dc_done,
  output logic          mem_en,
  output logic          mem_wr,
  output logic [15:0]   mem_addr,
  output logic [15:0]   mem_wdata,
  input  logic [15:0]   mem_rdata,
  output logic          busy,
  output logic [1:0]    dbgState
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2, DONE = 2'd3} stateT;

  localparam logic [15:0] LINE_MASK = 16'(2 * LINE_WORDS - 1);

  stateT              state;
  logic               ownerDc;
  logic               lastOwnerDc;
  logic               wrLat;
  logic [15:0]        base;
  logic [IW-1:0]      issueCnt;
  logic [IW:0]        retCnt;
  logic [MEM_LAT-1:0] vldPipe;
  logic [IW-1:0]      idxPipe [MEM_LAT];

  logic          pickDc;
  logic          issuing;
  logic          issueRd;
  logic          retValid;
  logic          lastReturn;
  logic [IW-1:0] retIdx;

  // With both requesting, the side that did not own the port last time wins.
  assign pickDc     = dc_req && (!ic_req || !lastOwnerDc);
  assign issuing    = (state == ISSUE);
  assign issueRd    = issuing && !wrLat;
  assign retValid   = vldPipe[MEM_LAT-1];
  assign retIdx     = idxPipe[MEM_LAT-1];
  assign lastReturn = (retCnt + (IW+1)'(retValid)) == (IW+1)'(LINE_WORDS);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      ownerDc     <= 1'b0;
      lastOwnerDc <= 1'b1;
      wrLat       <= 1'b0;
      base        <= '0;
      issueCnt    <= '0;
      retCnt      <= '0;
      vldPipe     <= '0;
      for (int i = 0; i < MEM_LAT; i++) idxPipe[i] <= '0;
    end else begin
      vldPipe[0] <= issueRd;
      idxPipe[0] <= issueCnt;
      for (int i = 1; i < MEM_LAT; i++) begin
        vldPipe[i] <= vldPipe[i-1];
        idxPipe[i] <= idxPipe[i-1];
      end
      if (retValid) retCnt <= retCnt + 1'b1;

      case (state)
        IDLE: begin
          if (ic_req || dc_req) begin
            ownerDc     <= pickDc;
            lastOwnerDc <= pickDc;
            wrLat       <= pickDc && dc_wr;
            base        <= (pickDc ? dc_addr : ic_addr) & ~LINE_MASK;
            issueCnt    <= '0;
            retCnt      <= '0;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          issueCnt <= issueCnt + 1'b1;
          if (issueCnt == IW'(LINE_WORDS - 1)) state <= wrLat ? DONE : DRAIN;
        end
        DRAIN: begin
          // Leave as the final word returns so DONE lands on the following cycle.
          if (lastReturn) state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign dbgState  = state;
  assign ic_grant  = busy && !ownerDc;
  assign dc_grant  = busy && ownerDc;
  assign ic_done   = (state == DONE) && !ownerDc;
  assign dc_done   = (state == DONE) && ownerDc;

  assign mem_en    = issuing;
  assign mem_wr    = issuing && wrLat;
  assign mem_addr  = issuing ? base + 16'({issueCnt, 1'b0}) : '0;
  assign mem_wdata = (issuing && wrLat) ? dc_wdata : '0;

  assign ic_rvalid = retValid && !ownerDc;
  assign dc_rvalid = retValid && ownerDc;
  assign ic_rdata  = ic_rvalid ? mem_rdata : '0;
  assign dc_rdata  = dc_rvalid ? mem_rdata : '0;
  assign ic_widx   = ic_rvalid ? retIdx : '0;
  assign dc_widx   = (issuing && wrLat) ? issueCnt : (dc_rvalid ? retIdx : '0);

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: one instance at MEM_LAT=2, one at MEM_LAT=4,
// each with a small fixed-latency memory whose read data is a function of the address.
module tb_cache_mem_arbiter;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Instance A (MEM_LAT=2)
  logic          icReq = 1'b0, dcReq = 1'b0, dcWr = 1'b0;
  logic [15:0]   icAddr = '0, dcAddr = '0;
  logic [15:0]   dcWdata, memRdata;
  logic          icGrant, icRvalid, icDone, dcGrant, dcRvalid, dcDone;
  logic          memEn, memWr, busy;
  logic [15:0]   icRdata, dcRdata, memAddr, memWdata;
  logic [IW-1:0] icWidx, dcWidx;
  logic [1:0]    dbgState;

  // Instance B (MEM_LAT=4), ICache side only
  logic          icReq4 = 1'b0;
  logic [15:0]   icAddr4 = '0;
  logic [15:0]   memRdata4;
  logic          icGrant4, icRvalid4, icDone4, dcGrant4, dcRvalid4, dcDone4;
  logic          memEn4, memWr4, busy4;
  logic [15:0]   icRdata4, dcRdata4, memAddr4, memWdata4;
  logic [IW-1:0] icWidx4, dcWidx4;
  logic [1:0]    dbgState4;

  assign dcWdata = 16'hA000 + 16'(dcWidx);

  cache_mem_arbiter #(.MEM_LAT(2), .LINE_WORDS(4)) dut (
    .clk(clk), .rst(rst),
    .ic_req(icReq), .ic_addr(icAddr), .ic_grant(icGrant), .ic_rvalid(icRvalid),
    .ic_rdata(icRdata), .ic_widx(icWidx), .ic_done(icDone),
    .dc_req(dcReq), .dc_wr(dcWr), .dc_addr(dcAddr), .dc_wdata(dcWdata),
    .dc_grant(dcGrant), .dc_rvalid(dcRvalid), .dc_rdata(dcRdata), .dc_widx(dcWidx),
    .dc_done(dcDone), .mem_en(memEn), .mem_wr(memWr), .mem_addr(memAddr),
    .mem_wdata(memWdata), .mem_rdata(memRdata), .busy(busy), .dbgState(dbgState)
  );

  cache_mem_arbiter #(.MEM_LAT(4), .LINE_WORDS(4)) dut4 (
    .clk(clk), .rst(rst),
    .ic_req(icReq4), .ic_addr(icAddr4), .ic_grant(icGrant4), .ic_rvalid(icRvalid4),
    .ic_rdata(icRdata4), .ic_widx(icWidx4), .ic_done(icDone4),
    .dc_req(1'b0), .dc_wr(1'b0), .dc_addr(16'h0000), .dc_wdata(16'h0000),
    .dc_grant(dcGrant4), .dc_rvalid(dcRvalid4), .dc_rdata(dcRdata4), .dc_widx(dcWidx4),
    .dc_done(dcDone4), .mem_en(memEn4), .mem_wr(memWr4), .mem_addr(memAddr4),
    .mem_wdata(memWdata4), .mem_rdata(memRdata4), .busy(busy4), .dbgState(dbgState4)
  );

  function automatic logic [15:0] memData(input logic [15:0] a);
    return a ^ 16'hC3A5;
  endfunction

  // Fixed-latency memories; non-read cycles return a junk pattern.
  logic [15:0] rdPipe  [2];
  logic [15:0] rdPipe4 [4];
  always @(posedge clk) begin
    rdPipe[0] <= (memEn && !memWr) ? memData(memAddr) : 16'hDEAD;
    rdPipe[1] <= rdPipe[0];
    rdPipe4[0] <= (memEn4 && !memWr4) ? memData(memAddr4) : 16'hDEAD;
    for (int i = 1; i < 4; i++) rdPipe4[i] <= rdPipe4[i-1];
  end
  assign memRdata  = rdPipe[1];
  assign memRdata4 = rdPipe4[3];

  logic [78:0] allA, allB;
  assign allA = {icGrant, icRvalid, icRdata, icWidx, icDone, dcGrant, dcRvalid, dcRdata,
                 dcWidx, dcDone, memEn, memWr, memAddr, memWdata, busy, dbgState};
  assign allB = {icGrant4, icRvalid4, icRdata4, icWidx4, icDone4, dcGrant4, dcRvalid4,
                 dcRdata4, dcWidx4, dcDone4, memEn4, memWr4, memAddr4, memWdata4, busy4,
                 dbgState4};
  logic [8:0] ctrlA;
  assign ctrlA = {icGrant, icRvalid, icDone, dcGrant, dcRvalid, dcDone, memEn, memWr, busy};

  task automatic test_reset();
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (allA !== '0) begin failures++; $display("FAIL reset_outs_a got=%h exp=0", allA); end
    checks++;
    if (allB !== '0) begin failures++; $display("FAIL reset_outs_b got=%h exp=0", allB); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (allA !== '0) begin failures++; $display("FAIL idle_outs_a got=%h exp=0", allA); end
  endtask

  task automatic test_ic_fill();
    logic [8:0] exp;
    logic iss, rv, dn, gr;
    @(negedge clk);
    icAddr = 16'h1236; icReq = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      iss = (k <= 4); rv = (k >= 3 && k <= 6); dn = (k == 7); gr = (k <= 7);
      exp = {gr, rv, dn, 1'b0, 1'b0, 1'b0, iss, 1'b0, gr};
      checks++;
      if (ctrlA !== exp) begin failures++; $display("FAIL ic_ctrl k=%0d got=%b exp=%b", k, ctrlA, exp); end
      if (iss) begin
        checks++;
        if (memAddr !== 16'h1230 + 16'(2 * (k - 1))) begin
          failures++; $display("FAIL ic_addr k=%0d got=%h exp=%h", k, memAddr, 16'h1230 + 16'(2 * (k - 1)));
        end
      end
      if (rv) begin
        checks++;
        if (icWidx !== IW'(k - 3) || icRdata !== memData(16'h1230 + 16'(2 * (k - 3)))) begin
          failures++; $display("FAIL ic_ret k=%0d got=%0d/%h exp=%0d/%h", k, icWidx, icRdata,
                               k - 3, memData(16'h1230 + 16'(2 * (k - 3))));
        end
      end
      checks++;
      if ({dcRdata, dcWidx} !== '0) begin failures++; $display("FAIL ic_dc_quiet k=%0d got=%h exp=0", k, {dcRdata, dcWidx}); end
      if (k == 7) icReq = 1'b0;
    end
  endtask

  task automatic test_dc_writeback();
    logic [8:0] exp;
    logic iss, dn, gr;
    @(negedge clk);
    dcAddr = 16'h00F8; dcWr = 1'b1; dcReq = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      iss = (k <= 4); dn = (k == 5); gr = (k <= 5);
      exp = {1'b0, 1'b0, 1'b0, gr, 1'b0, dn, iss, iss, gr};
      checks++;
      if (ctrlA !== exp) begin failures++; $display("FAIL wb_ctrl k=%0d got=%b exp=%b", k, ctrlA, exp); end
      if (iss) begin
        checks++;
        if (memAddr !== 16'h00F8 + 16'(2 * (k - 1)) || memWdata !== 16'hA000 + 16'(k - 1) ||
            dcWidx !== IW'(k - 1)) begin
          failures++; $display("FAIL wb_word k=%0d got=%h/%h/%0d exp=%h/%h/%0d", k, memAddr, memWdata,
                               dcWidx, 16'h00F8 + 16'(2 * (k - 1)), 16'hA000 + 16'(k - 1), k - 1);
        end
      end
      if (k == 5) begin dcReq = 1'b0; dcWr = 1'b0; end
    end
  endtask

  task automatic test_round_robin();
    logic icG, dcG;
    rst = 1'b0;
    icAddr = 16'h0300; dcAddr = 16'h0400; dcWr = 1'b0;
    icReq = 1'b1; dcReq = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      icG = (k <= 7) || (k == 17);
      dcG = (k >= 9 && k <= 15);
      checks++;
      if ({icGrant, dcGrant, busy} !== {icG, dcG, icG | dcG}) begin
        failures++; $display("FAIL rr_grant k=%0d got=%b exp=%b", k, {icGrant, dcGrant, busy}, {icG, dcG, icG | dcG});
      end
      if (k == 1 || k == 9 || k == 17) begin
        checks++;
        if (memAddr !== (k == 9 ? 16'h0400 : 16'h0300)) begin
          failures++; $display("FAIL rr_addr k=%0d got=%h exp=%h", k, memAddr, (k == 9 ? 16'h0400 : 16'h0300));
        end
      end
      if (k >= 11 && k <= 14) begin
        checks++;
        if (!dcRvalid || dcWidx !== IW'(k - 11) || dcRdata !== memData(16'h0400 + 16'(2 * (k - 11)))) begin
          failures++; $display("FAIL rr_dc_ret k=%0d got=%b/%0d/%h exp=1/%0d/%h", k, dcRvalid, dcWidx, dcRdata,
                               k - 11, memData(16'h0400 + 16'(2 * (k - 11))));
        end
      end
    end
    icReq = 1'b0; dcReq = 1'b0;
    wait_idle("rr_idle");
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL %s got busy=%b exp=0", name, busy); end
  endtask

  task automatic test_lat4();
    logic [4:0] exp;
    logic [1:0] expSt;
    logic iss, rv, dn, gr;
    @(negedge clk);
    icAddr4 = 16'h0040; icReq4 = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      iss = (k <= 4); rv = (k >= 5 && k <= 8); dn = (k == 9); gr = (k <= 9);
      exp = {gr, rv, dn, iss, gr};
      expSt = (k <= 4) ? 2'd1 : (k <= 8) ? 2'd2 : (k == 9) ? 2'd3 : 2'd0;
      checks++;
      if ({icGrant4, icRvalid4, icDone4, memEn4, busy4} !== exp || dbgState4 !== expSt || dcGrant4 !== 1'b0) begin
        failures++; $display("FAIL lat4_ctrl k=%0d got=%b st=%0d exp=%b st=%0d", k,
                             {icGrant4, icRvalid4, icDone4, memEn4, busy4}, dbgState4, exp, expSt);
      end
      if (rv) begin
        checks++;
        if (icWidx4 !== IW'(k - 5) || icRdata4 !== memData(16'h0040 + 16'(2 * (k - 5)))) begin
          failures++; $display("FAIL lat4_ret k=%0d got=%0d/%h exp=%0d/%h", k, icWidx4, icRdata4,
                               k - 5, memData(16'h0040 + 16'(2 * (k - 5))));
        end
      end
      if (k == 9) icReq4 = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    icAddr = 16'h2000; icReq = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (icRvalid !== 1'b1) begin failures++; $display("FAIL mid_pre_rvalid got=%b exp=1", icRvalid); end
    icReq = 1'b0;
    #1 rst = 1'b0;
    #1;
    checks++;
    if (allA !== '0) begin failures++; $display("FAIL mid_async_outs got=%h exp=0", allA); end
    @(negedge clk);
    checks++;
    if (ctrlA !== '0) begin failures++; $display("FAIL mid_in_reset got=%b exp=0", ctrlA); end
    rst = 1'b1;
    for (int k = 5; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if (ctrlA !== '0) begin failures++; $display("FAIL mid_late_data k=%0d got=%b exp=0", k, ctrlA); end
    end
    icReq = 1'b1; dcReq = 1'b1; dcWr = 1'b1; dcAddr = 16'h0500;
    @(negedge clk);
    checks++;
    if ({icGrant, dcGrant} !== 2'b10) begin failures++; $display("FAIL mid_first_owner got=%b exp=10", {icGrant, dcGrant}); end
    icReq = 1'b0; dcReq = 1'b0; dcWr = 1'b0;
    wait_idle("mid_idle");
  endtask

  task automatic test_dc_drop();
    int enCnt = 0, rvCnt = 0, doneCnt = 0;
    @(negedge clk);
    dcAddr = 16'h0106; dcWr = 1'b0; dcReq = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (memEn) enCnt++;
      if (dcDone) doneCnt++;
      if (dcRvalid) begin
        checks++;
        if (dcWidx !== IW'(rvCnt) || dcRdata !== memData(16'h0100 + 16'(2 * rvCnt))) begin
          failures++; $display("FAIL drop_ret k=%0d got=%0d/%h exp=%0d/%h", k, dcWidx, dcRdata,
                               rvCnt, memData(16'h0100 + 16'(2 * rvCnt)));
        end
        rvCnt++;
      end
      if (k == 2) dcReq = 1'b0;
    end
    checks++;
    if (enCnt != 4) begin failures++; $display("FAIL drop_issue_count got=%0d exp=4", enCnt); end
    checks++;
    if (rvCnt != 4) begin failures++; $display("FAIL drop_return_count got=%0d exp=4", rvCnt); end
    checks++;
    if (doneCnt != 1) begin failures++; $display("FAIL drop_done_count got=%0d exp=1", doneCnt); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL drop_idle got=%b exp=0", busy); end
  endtask

  initial begin
    test_reset();
    test_ic_fill();
    test_dc_writeback();
    test_round_robin();
    test_lat4();
    test_reset_mid();
    test_dc_drop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
